// File: rtl/a2d_intf.sv
// a2d_intf: SPI master that runs a two-transfer ADC conversion and returns a 12-bit result
module a2d_intf #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);
  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] HM1 = DW'(SCLK_DIV / 2 - 1);
  localparam logic [DW-1:0] LAST = DW'(SCLK_DIV - 1);
  typedef enum logic [2:0] {IDLE, XFER1, PAUSE, XFER2, CMPLT} state_t;
  state_t state;
  logic [DW-1:0] div;
  logic [3:0] bitc;
  logic [15:0] tx, rx;
  logic [2:0] chan;
  logic last;
  assign last = div == LAST;
  // Outputs are registered alongside the state, so each is computed for the cycle after the edge
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      div <= '0;
      bitc <= '0;
      tx <= '0;
      rx <= '0;
      chan <= '0;
      res <= '0;
      cnv_cmplt <= 1'b0;
      SS_n <= 1'b1;
      SCLK <= 1'b1;
      MOSI <= 1'b0;
    end else
      case (state)
        IDLE: if (strt_cnv) begin
          state <= XFER1;
          chan <= chnnl;
          tx <= {2'b00, chnnl, 11'h000};
          rx <= '0;
          cnv_cmplt <= 1'b0;
          div <= '0;
          bitc <= '0;
          SS_n <= 1'b0;
          SCLK <= 1'b0;
          MOSI <= 1'b0;
        end
        PAUSE: if (last) begin
          state <= XFER2;
          tx <= {2'b00, chan, 11'h000};
          div <= '0;
          bitc <= '0;
          SS_n <= 1'b0;
          SCLK <= 1'b0;
          MOSI <= 1'b0;
        end else
          div <= div + 1'b1;
        XFER1, XFER2: begin
          div <= last ? '0 : div + 1'b1;
          SCLK <= !last && div >= HM1;
          if (div == HM1) rx <= {rx[14:0], MISO};
          if (last) begin
            tx <= {tx[14:0], 1'b0};
            MOSI <= tx[14];
            bitc <= bitc + 1'b1;
            if (bitc == 4'd15) begin
              state <= state == XFER1 ? PAUSE : CMPLT;
              SS_n <= 1'b1;
              SCLK <= 1'b1;
              MOSI <= 1'b0;
              if (state == XFER2) begin
                res <= rx[11:0];
                cnv_cmplt <= 1'b1;
              end
            end
          end
        end
        CMPLT: state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_a2d_intf.sv
// tb_a2d_intf: scoreboard bench for a2d_intf with an SPI ADC model and timing monitor
module tb_a2d_intf;
  localparam int DIV = 32;
  localparam int LAT = 1 + 33 * DIV;
  logic clk = 0, rst_n = 0, strt_cnv = 0, MISO;
  logic [2:0] chnnl = '0;
  logic cnv_cmplt, SS_n, SCLK, MOSI;
  logic [11:0] res;
  a2d_intf #(.SCLK_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [11:0] res;
    int cyc;
    int width;
  } exp_t;
  exp_t exp_q[$];
  logic [15:0] cmd_q[$];
  logic [15:0] adc_q[$];
  int cyc = 0, compared = 0, mismatched = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // ADC model: bit 15-k of the current word is presented until the k-th SCLK rise is seen
  logic [15:0] adc_word = '0;
  int bitk = 0;
  assign MISO = bitk < 16 ? adc_word[4'(15 - bitk)] : 1'b0;
  int low_cnt = 0, high_cnt = 0, rises = 0, xfer_no = 0, cw = 0, cm_width = 0;
  logic [15:0] mosi_word = '0;
  logic sclk_q = 1, ss_q = 1, rst_q = 0, cm_q = 0;
  logic [11:0] res_q = '0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_q) begin
      exp_q.delete();
      cmd_q.delete();
      low_cnt = 0;
      high_cnt = 0;
      rises = 0;
      xfer_no = 0;
      bitk = 0;
      cw = 0;
      cm_width = 0;
    end else begin
      if (!SS_n && ss_q) begin
        adc_word = adc_q.size() > 0 ? adc_q.pop_front() : 16'h0000;
        bitk = 0;
        rises = 0;
        mosi_word = '0;
        if (xfer_no == 1) check("pause_len", high_cnt, 32);
        low_cnt = 0;
      end
      if (SS_n && !ss_q) begin
        check("ss_low_len", low_cnt, 16 * DIV);
        check("sclk_rises", rises, 16);
        check("cmd_expected", 32'(cmd_q.size() > 0), 1);
        if (cmd_q.size() > 0) check("mosi_cmd", mosi_word, cmd_q.pop_front());
        xfer_no ^= 1;
        high_cnt = 0;
      end
      if (SS_n) high_cnt++;
      else low_cnt++;
      if (SCLK && !sclk_q && !SS_n) begin
        rises++;
        mosi_word = {mosi_word[14:0], MOSI};
        bitk++;
      end
      if (SS_n) check("idle_sclk_mosi", {SCLK, MOSI}, 2'b10);
      if (cnv_cmplt && !cm_q) begin
        check("cmplt_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("res", res, e.res);
          check("latency", cyc, e.cyc);
          cm_width = e.width;
        end
        cw = 0;
      end else if (res !== res_q)
        check("res_held", res, res_q);
      if (cnv_cmplt) cw++;
      if (!cnv_cmplt && cm_q && cm_width != 0) check("cmplt_width", cw, cm_width);
    end
    rst_q = rst_n;
    ss_q = SS_n;
    sclk_q = SCLK;
    cm_q = cnv_cmplt;
    res_q = res;
  end
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_until(int t);
    while (cyc < t) step();
  endtask
  task automatic expect_conv(logic [15:0] cmd, logic [15:0] junk, logic [15:0] word,
                             logic [11:0] r, int acc, int w);
    cmd_q.push_back(cmd);
    cmd_q.push_back(cmd);
    adc_q.push_back(junk);
    adc_q.push_back(word);
    exp_q.push_back('{r, acc + LAT, w});
  endtask
  int n, toggles;
  logic sp;
  initial begin
    step(3);
    check("rst_ss_n", SS_n, 1);
    check("rst_sclk", SCLK, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_cmplt", cnv_cmplt, 0);
    check("rst_res", res, 0);
    rst_n = 1;
    step(2);
    // basic conversion, channel 5
    n = cyc;
    strt_cnv = 1;
    chnnl = 3'd5;
    expect_conv(16'h2800, 16'hFFFF, 16'h0ABC, 12'hABC, n, 0);
    step();
    strt_cnv = 0;
    chnnl = 3'd6;
    wait_until(n + LAT + 3);
    // accept while cnv_cmplt is still high, then busy re-pulses with channel 2
    check("cmplt_before_accept", cnv_cmplt, 1);
    n = cyc;
    strt_cnv = 1;
    chnnl = 3'd5;
    expect_conv(16'h2800, 16'h5A5A, 16'h0456, 12'h456, n, 0);
    step();
    check("cmplt_cleared", cnv_cmplt, 0);
    strt_cnv = 0;
    wait_until(n + 100);
    strt_cnv = 1;
    chnnl = 3'd2;
    step();
    strt_cnv = 0;
    wait_until(n + 700);
    strt_cnv = 1;
    chnnl = 3'd2;
    step();
    strt_cnv = 0;
    wait_until(n + LAT + 3);
    // back-to-back with strt_cnv held: cnv_cmplt spans CMPLT plus the accepting IDLE cycle
    n = cyc;
    strt_cnv = 1;
    chnnl = 3'd1;
    expect_conv(16'h0800, 16'hFFFF, 16'h0111, 12'h111, n, 2);
    expect_conv(16'h0800, 16'h0000, 16'h0222, 12'h222, n + LAT + 1, 2);
    expect_conv(16'h0800, 16'hAAAA, 16'h0333, 12'h333, n + 2 * LAT + 2, 0);
    wait_until(n + 2 * LAT + 10);
    strt_cnv = 0;
    wait_until(n + 3 * LAT + 5);
    // reset in the middle of XFER2
    n = cyc;
    strt_cnv = 1;
    chnnl = 3'd3;
    expect_conv(16'h1800, 16'hFFFF, 16'h0777, 12'h777, n, 0);
    step();
    strt_cnv = 0;
    wait_until(n + 700);
    rst_n = 0;
    step();
    rst_n = 1;
    check("abort_ss_n", SS_n, 1);
    check("abort_sclk", SCLK, 1);
    check("abort_cmplt", cnv_cmplt, 0);
    check("abort_res", res, 0);
    toggles = 0;
    sp = SCLK;
    repeat (300) begin
      step();
      if (SCLK !== sp) toggles++;
      sp = SCLK;
    end
    check("no_sclk_after_abort", toggles, 0);
    // upper ADC bits masked, channel 7
    n = cyc;
    strt_cnv = 1;
    chnnl = 3'd7;
    expect_conv(16'h3800, 16'h0000, 16'hF123, 12'h123, n, 0);
    step();
    strt_cnv = 0;
    wait_until(n + LAT + 5);
    check("exp_left", exp_q.size(), 0);
    check("cmd_left", cmd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
